// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss-handling controller between the CPU caches and multi-cycle main
//   memory. On a miss it latches the block-aligned address, issues one word
//   read per cycle, writes each returned word into the cache data array and
//   writes the tag together with the final word.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   miss_detected       cache lookup missed this cycle (sampled in IDLE only)
//   miss_address        byte address of the missing access
//   memory_data         word returned by main memory
//   memory_data_valid   memory_data valid this cycle (ignored in IDLE)
//   fsm_busy            fill in progress; pipeline stall
//   mem_req             memory read request strobe (registered)
//   memory_address      byte address of the current request (registered)
//   write_data_array    data-array write enable
//   word_index          data-array word being written
//   write_data          data to write (memory_data passthrough)
//   write_tag_array     tag/valid write enable, asserted with the final word
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  localparam int IDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  word_index,
  output logic [15:0]       write_data,
  output logic              write_tag_array
);

  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [0:0] {
    IDLE,
    FILL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [ADDR_W-1:0] aligned;
  logic [CNT_W-1:0]  req_nxt;

  assign aligned    = miss_address & ~OFF_MASK;
  assign req_nxt    = req_cnt_q + CNT_W'(1);
  assign write_data = memory_data;

  assign mem_req        = mem_req_q;
  assign memory_address = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      base_q    <= '0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      base_q    <= base_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
    end
  end

  // Requests are registered one cycle ahead: the request presented now
  // (mem_req_q) is counted this cycle, and the next one is prepared for the
  // following cycle. The word offset is OR-ed into the aligned base so the
  // address never carries out of the block.
  always_comb begin
    state_d          = state_q;
    req_cnt_d        = req_cnt_q;
    rcv_cnt_d        = rcv_cnt_q;
    base_d           = base_q;
    mem_req_d        = 1'b0;
    addr_d           = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d    = aligned;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          mem_req_d = 1'b1;
          addr_d    = aligned;
          state_d   = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        if (mem_req_q) begin
          req_cnt_d = req_nxt;
          if (req_nxt < CNT_END) begin
            mem_req_d = 1'b1;
            addr_d    = base_q | ADDR_W'({req_nxt[IDX_W-1:0], 1'b0});
          end
        end

        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = rcv_cnt_q[IDX_W-1:0];
          rcv_cnt_d        = rcv_cnt_q + CNT_W'(1);
          if (rcv_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            mem_req_d       = 1'b0;
            addr_d          = '0;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic [15:0] write_data;
  logic        write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK(8),
    .ADDR_W         (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data      (memory_data),
    .memory_data_valid(memory_data_valid),
    .fsm_busy         (fsm_busy),
    .mem_req          (mem_req),
    .memory_address   (memory_address),
    .write_data_array (write_data_array),
    .word_index       (word_index),
    .write_data       (write_data),
    .write_tag_array  (write_tag_array)
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
  } wr_t;

  pend_t       mem_pend[$];
  logic [15:0] req_q[$];
  wr_t         wr_q[$];

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          wr_seen = 0;
  int          tag_seen = 0;
  int          gap_rem = 0;
  logic [2:0]  gap_idx = 3'd0;
  logic [15:0] data_base = 16'hA000;
  bit          stray = 1'b0;
  bit          exp_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample at negedge, compare,
  // update the reference model, then advance past the posedge.
  task automatic cycle();
    pend_t       p;
    wr_t         w;
    logic [15:0] a;
    bit          last_now;
    last_now          = 1'b0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    if (mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
      if (gap_rem > 0 && mem_pend[0].addr[3:1] == gap_idx) begin
        gap_rem--;
      end else begin
        p                 = mem_pend.pop_front();
        w.idx             = p.addr[3:1];
        w.data            = data_base + 16'(p.addr[3:1]);
        w.tag             = (p.addr[3:1] == 3'd7);
        memory_data_valid = 1'b1;
        memory_data       = w.data;
        wr_q.push_back(w);
      end
    end else if (stray && !exp_busy) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end

    @(negedge clk);
    chk("fsm_busy", 32'(fsm_busy), 32'(exp_busy));

    if (mem_req === 1'b1) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL mem_req: observed request addr=%0h expected no request", memory_address);
      end else begin
        a = req_q.pop_front();
        chk("memory_address", 32'(memory_address), 32'(a));
        mem_pend.push_back('{cyc + LAT, a});
      end
    end else if (!exp_busy) begin
      chk("idle_req_addr", {15'd0, mem_req, memory_address}, 32'd0);
    end

    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      wr_seen++;
      if (w.tag) tag_seen++;
      chk("write_data_array", 32'(write_data_array), 32'd1);
      chk("word_index", 32'(word_index), 32'(w.idx));
      chk("write_data", 32'(write_data), 32'(w.data));
      chk("write_tag_array", 32'(write_tag_array), 32'(w.tag));
      last_now = w.tag;
    end else begin
      chk("no_write", {30'd0, write_data_array, write_tag_array}, 32'd0);
      if (!exp_busy) chk("idle_word_index", 32'(word_index), 32'd0);
    end

    if (rst) begin
      exp_busy = 1'b0;
      req_q.delete();
      mem_pend.delete();
      wr_q.delete();
    end else if (last_now) begin
      exp_busy = 1'b0;
    end else if (!exp_busy && miss_detected) begin
      exp_busy = 1'b1;
      for (int i = 0; i < 8; i++)
        req_q.push_back((miss_address & 16'hFFF0) + 16'(2 * i));
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while ((exp_busy || req_q.size() > 0 || mem_pend.size() > 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (exp_busy || req_q.size() > 0 || mem_pend.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL timeout_%s: observed still busy after %0d cycles, expected idle", tag, n);
    end
  endtask

  task automatic start_miss(input logic [15:0] addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    cycle();
    miss_detected = 1'b0;
  endtask

  initial begin
    int n;
    int t0;
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data       = 16'h0000;
    memory_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();

    // Basic fill
    data_base = 16'hA000;
    start_miss(16'h1236);
    run_until_idle(60, "basic");
    repeat (2) cycle();

    // Top-of-address-space block, no wrap
    data_base = 16'hB100;
    start_miss(16'hFFFF);
    run_until_idle(60, "high");
    cycle();

    // Miss pulse mid-fill is ignored; stray valids in IDLE write nothing
    data_base = 16'hC200;
    start_miss(16'h2000);
    repeat (2) cycle();
    start_miss(16'h4000);
    run_until_idle(60, "ignore");
    repeat (3) cycle();
    stray = 1'b1;
    repeat (2) cycle();
    stray = 1'b0;
    cycle();

    // Reset after three words written, then a clean fill
    data_base = 16'hD300;
    start_miss(16'h3000);
    t0 = wr_seen;
    n  = 0;
    while (wr_seen < t0 + 3 && n < 40) begin
      cycle();
      n++;
    end
    if (wr_seen < t0 + 3) begin
      checks++;
      errors++;
      $error("FAIL timeout_midreset: observed %0d writes, expected 3", wr_seen - t0);
    end
    t0  = tag_seen;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    chk("no_tag_after_reset", 32'(tag_seen - t0), 32'd0);
    data_base = 16'hE400;
    start_miss(16'h0040);
    run_until_idle(60, "post_reset");
    cycle();

    // Two-cycle gap in returns between words 3 and 4
    data_base = 16'h1500;
    gap_idx   = 3'd4;
    gap_rem   = 2;
    start_miss(16'h5008);
    run_until_idle(60, "gap");
    chk("gap_consumed", 32'(gap_rem), 32'd0);
    cycle();

    // Miss held high: one fill, a single IDLE cycle, then a fill of the
    // address presented at that time
    data_base     = 16'h2600;
    t0            = tag_seen;
    miss_detected = 1'b1;
    miss_address  = 16'h6000;
    n             = 0;
    while (tag_seen < t0 + 2 && n < 100) begin
      cycle();
      if (n == 3) miss_address = 16'h7010;
      n++;
    end
    miss_detected = 1'b0;
    chk("b2b_fills", 32'(tag_seen - t0), 32'd2);
    run_until_idle(60, "b2b");
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
